// File: rtl/pool_arbiter.sv
// Round-robin arbiter sharing one memory read port and one write port among N processors.
// The read and write channels are independent two-state FSMs, each with its own rotating pointer.
`ifndef PROC_COUNT
`define PROC_COUNT 4
`endif
`ifndef BUS_W
`define BUS_W 16
`endif

package pool_arbiter_pkg;
    typedef logic [15:0] addr_t;
endpackage

module pool_arbiter
    import pool_arbiter_pkg::*;
#(
    parameter int N  = `PROC_COUNT,
    parameter int DW = `BUS_W,
    parameter int AW = $bits(addr_t)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [N-1:0]         i_req_rd,
    input  logic [N-1:0]         i_req_wr,
    input  logic [N-1:0][AW-1:0] i_addr,
    input  logic [N-1:0][DW-1:0] i_data,
    input  logic [N-1:0][2:0]    i_wr_size,
    output logic [N-1:0]         o_grant_rd,
    output logic [N-1:0]         o_grant_wr,
    output logic [N-1:0]         o_valid,
    output logic [DW-1:0]        o_rd_data,
    output logic                 o_mem_rd_en,
    output logic [AW-1:0]        o_mem_rd_addr,
    input  logic                 i_mem_rd_valid,
    input  logic [DW-1:0]        i_mem_rd_data,
    output logic                 o_mem_wr_en,
    output logic [AW-1:0]        o_mem_wr_addr,
    output logic [DW-1:0]        o_mem_wr_data,
    output logic [2:0]           o_mem_wr_size,
    input  logic                 i_mem_wr_ack
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {R_IDLE, R_WAIT} rd_state_t;
    typedef enum logic {W_IDLE, W_ACK}  wr_state_t;

    // First requester at or above ptr, wrapping N-1 -> 0.
    function automatic logic [PW-1:0] rr_pick(input logic [N-1:0] req, input logic [PW-1:0] ptr);
        logic [PW-1:0] sel;
        logic [PW-1:0] idx;
        logic          found;
        int            t;
        sel   = ptr;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            t = int'(ptr) + k;
            if (t >= N) t = t - N;
            idx = PW'(t);
            if (!found && req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] sel);
        if (int'(sel) == N - 1) return '0;
        return sel + PW'(1);
    endfunction

    rd_state_t          r_rd_state, w_rd_state_next;
    logic [PW-1:0]      r_rd_ptr, w_rd_ptr_next;
    logic [PW-1:0]      r_rd_sel, w_rd_sel_next;
    logic [N-1:0]       r_grant_rd, w_grant_rd_next;
    logic               r_mem_rd_en, w_mem_rd_en_next;
    logic [AW-1:0]      r_mem_rd_addr, w_mem_rd_addr_next;
    logic [N-1:0]       r_valid, w_valid_next;
    logic [DW-1:0]      r_rd_data, w_rd_data_next;

    wr_state_t          r_wr_state, w_wr_state_next;
    logic [PW-1:0]      r_wr_ptr, w_wr_ptr_next;
    logic [PW-1:0]      r_wr_sel, w_wr_sel_next;
    logic [N-1:0]       r_grant_wr, w_grant_wr_next;
    logic               r_mem_wr_en, w_mem_wr_en_next;
    logic [AW-1:0]      r_mem_wr_addr, w_mem_wr_addr_next;
    logic [DW-1:0]      r_mem_wr_data, w_mem_wr_data_next;
    logic [2:0]         r_mem_wr_size, w_mem_wr_size_next;

    logic [PW-1:0]      w_rd_pick, w_wr_pick;
    logic [N-1:0]       w_rd_onehot, w_wr_onehot;

    assign w_rd_pick = rr_pick(i_req_rd, r_rd_ptr);
    assign w_wr_pick = rr_pick(i_req_wr, r_wr_ptr);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_onehot
            assign w_rd_onehot[gi] = (w_rd_pick == PW'(gi));
            assign w_wr_onehot[gi] = (w_wr_pick == PW'(gi));
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_state    <= R_IDLE;
            r_rd_ptr      <= '0;
            r_rd_sel      <= '0;
            r_grant_rd    <= '0;
            r_mem_rd_en   <= 1'b0;
            r_mem_rd_addr <= '0;
            r_valid       <= '0;
            r_rd_data     <= '0;
        end else begin
            r_rd_state    <= w_rd_state_next;
            r_rd_ptr      <= w_rd_ptr_next;
            r_rd_sel      <= w_rd_sel_next;
            r_grant_rd    <= w_grant_rd_next;
            r_mem_rd_en   <= w_mem_rd_en_next;
            r_mem_rd_addr <= w_mem_rd_addr_next;
            r_valid       <= w_valid_next;
            r_rd_data     <= w_rd_data_next;
        end
    end

    always_comb begin
        w_rd_state_next    = r_rd_state;
        w_rd_ptr_next      = r_rd_ptr;
        w_rd_sel_next      = r_rd_sel;
        w_grant_rd_next    = r_grant_rd;
        w_mem_rd_en_next   = 1'b0;
        w_mem_rd_addr_next = r_mem_rd_addr;
        w_valid_next       = '0;
        w_rd_data_next     = r_rd_data;
        case (r_rd_state)
            R_IDLE: begin
                if (|i_req_rd) begin
                    w_rd_sel_next      = w_rd_pick;
                    w_grant_rd_next    = w_rd_onehot;
                    w_mem_rd_en_next   = 1'b1;
                    w_mem_rd_addr_next = i_addr[w_rd_pick];
                    w_rd_state_next    = R_WAIT;
                end
            end
            R_WAIT: begin
                // The held grant is already the one-hot of the winner, so it doubles as the valid mask.
                if (i_mem_rd_valid) begin
                    w_rd_data_next  = i_mem_rd_data;
                    w_valid_next    = r_grant_rd;
                    w_grant_rd_next = '0;
                    w_rd_ptr_next   = ptr_after(r_rd_sel);
                    w_rd_state_next = R_IDLE;
                end
            end
            default: w_rd_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_state    <= W_IDLE;
            r_wr_ptr      <= '0;
            r_wr_sel      <= '0;
            r_grant_wr    <= '0;
            r_mem_wr_en   <= 1'b0;
            r_mem_wr_addr <= '0;
            r_mem_wr_data <= '0;
            r_mem_wr_size <= '0;
        end else begin
            r_wr_state    <= w_wr_state_next;
            r_wr_ptr      <= w_wr_ptr_next;
            r_wr_sel      <= w_wr_sel_next;
            r_grant_wr    <= w_grant_wr_next;
            r_mem_wr_en   <= w_mem_wr_en_next;
            r_mem_wr_addr <= w_mem_wr_addr_next;
            r_mem_wr_data <= w_mem_wr_data_next;
            r_mem_wr_size <= w_mem_wr_size_next;
        end
    end

    always_comb begin
        w_wr_state_next    = r_wr_state;
        w_wr_ptr_next      = r_wr_ptr;
        w_wr_sel_next      = r_wr_sel;
        w_grant_wr_next    = r_grant_wr;
        w_mem_wr_en_next   = 1'b0;
        w_mem_wr_addr_next = r_mem_wr_addr;
        w_mem_wr_data_next = r_mem_wr_data;
        w_mem_wr_size_next = r_mem_wr_size;
        case (r_wr_state)
            W_IDLE: begin
                if (|i_req_wr) begin
                    w_wr_sel_next      = w_wr_pick;
                    w_grant_wr_next    = w_wr_onehot;
                    w_mem_wr_en_next   = 1'b1;
                    w_mem_wr_addr_next = i_addr[w_wr_pick];
                    w_mem_wr_data_next = i_data[w_wr_pick];
                    w_mem_wr_size_next = i_wr_size[w_wr_pick];
                    w_wr_state_next    = W_ACK;
                end
            end
            W_ACK: begin
                if (i_mem_wr_ack) begin
                    w_grant_wr_next = '0;
                    w_wr_ptr_next   = ptr_after(r_wr_sel);
                    w_wr_state_next = W_IDLE;
                end
            end
            default: w_wr_state_next = W_IDLE;
        endcase
    end

    assign o_grant_rd    = r_grant_rd;
    assign o_grant_wr    = r_grant_wr;
    assign o_valid       = r_valid;
    assign o_rd_data     = r_rd_data;
    assign o_mem_rd_en   = r_mem_rd_en;
    assign o_mem_rd_addr = r_mem_rd_addr;
    assign o_mem_wr_en   = r_mem_wr_en;
    assign o_mem_wr_addr = r_mem_wr_addr;
    assign o_mem_wr_data = r_mem_wr_data;
    assign o_mem_wr_size = r_mem_wr_size;

endmodule

// File: tb/tb_pool_arbiter.sv
// Scoreboard bench for pool_arbiter: stimulus threads push expected transactions,
// a negedge monitor pops and compares them as the DUT presents strobes and valids.
module tb_pool_arbiter;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 16;

    logic                 clk;
    logic                 rst;
    logic [N-1:0]         req_rd, req_wr;
    logic [N-1:0][AW-1:0] addr;
    logic [N-1:0][DW-1:0] wr_data;
    logic [N-1:0][2:0]    wr_size;
    logic [N-1:0]         grant_rd, grant_wr, valid;
    logic [DW-1:0]        rd_data;
    logic                 mem_rd_en, mem_rd_valid, mem_wr_en, mem_wr_ack;
    logic [AW-1:0]        mem_rd_addr, mem_wr_addr;
    logic [DW-1:0]        mem_rd_data, mem_wr_data;
    logic [2:0]           mem_wr_size;

    pool_arbiter #(.N(N), .DW(DW), .AW(AW)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_rd(req_rd), .i_req_wr(req_wr), .i_addr(addr), .i_data(wr_data), .i_wr_size(wr_size),
        .o_grant_rd(grant_rd), .o_grant_wr(grant_wr), .o_valid(valid), .o_rd_data(rd_data),
        .o_mem_rd_en(mem_rd_en), .o_mem_rd_addr(mem_rd_addr),
        .i_mem_rd_valid(mem_rd_valid), .i_mem_rd_data(mem_rd_data),
        .o_mem_wr_en(mem_wr_en), .o_mem_wr_addr(mem_wr_addr), .o_mem_wr_data(mem_wr_data),
        .o_mem_wr_size(mem_wr_size), .i_mem_wr_ack(mem_wr_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  grant;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [2:0]    sz;
    } exp_t;

    exp_t          rd_q[$];
    exp_t          wr_q[$];
    exp_t          rd_cur, wr_cur;
    bit            rd_active, wr_active, ack_seen;
    int            n_checks, n_errors;
    int            rd_pushed, rd_done, wr_pushed, wr_done;
    int            rd_ptr_m, wr_ptr_m;
    logic [DW-1:0] mem [0:255];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        n_checks++;
        n_errors++;
        $display("FAIL %s: observed 0x%0h where nothing was expected", name, act);
    endtask

    // Round-robin rule: first requester at or above ptr, wrapping.
    function automatic int rr_model(input logic [N-1:0] req, input int ptr);
        int r;
        r = int'(req);
        for (int k = 0; k < N; k++)
            if (((r >> ((ptr + k) % N)) & 1) != 0) return (ptr + k) % N;
        return 0;
    endfunction

    function automatic logic [N-1:0] onehot(input int w);
        logic [N-1:0] one;
        one = 1;
        return one << w;
    endfunction

    task automatic push_rd(input logic [N-1:0] req);
        exp_t e;
        int   w;
        logic [AW-1:0] a;
        w = rr_model(req, rd_ptr_m);
        a = addr[2'(w)];
        e.grant = onehot(w);
        e.a = a;
        e.d = mem[a[7:0]];
        e.sz = '0;
        rd_q.push_back(e);
        rd_ptr_m = (w + 1) % N;
        rd_pushed++;
    endtask

    task automatic push_wr(input logic [N-1:0] req);
        exp_t e;
        int   w;
        w = rr_model(req, wr_ptr_m);
        e.grant = onehot(w);
        e.a = addr[2'(w)];
        e.d = wr_data[2'(w)];
        e.sz = wr_size[2'(w)];
        wr_q.push_back(e);
        wr_ptr_m = (w + 1) % N;
        wr_pushed++;
    endtask

    task automatic rd_txn(input logic [N-1:0] req, input int lat, input bit drop);
        int n;
        req_rd = req;
        push_rd(req);
        n = 0;
        do begin @(negedge clk); n++; end while (!mem_rd_en && n < 10);
        if (!mem_rd_en) begin
            fail_now("rd_en_timeout", 64'(n));
            req_rd = '0;
            return;
        end
        if (drop) req_rd = '0;
        repeat (lat) @(negedge clk);
        mem_rd_valid = 1'b1;
        mem_rd_data  = mem[mem_rd_addr[7:0]];
        @(negedge clk);
        mem_rd_valid = 1'b0;
        mem_rd_data  = DW'($urandom);
        req_rd = '0;
    endtask

    task automatic stray_rd();
        mem_rd_valid = 1'b1;
        mem_rd_data  = DW'($urandom);
        @(negedge clk);
        mem_rd_valid = 1'b0;
    endtask

    task automatic wr_txn(input logic [N-1:0] req, input logic [N-1:0][DW-1:0] d,
                          input logic [N-1:0][2:0] s, input int lat, input bit drop);
        int n;
        req_wr  = req;
        wr_data = d;
        wr_size = s;
        push_wr(req);
        n = 0;
        do begin @(negedge clk); n++; end while (!mem_wr_en && n < 10);
        if (!mem_wr_en) begin
            fail_now("wr_en_timeout", 64'(n));
            req_wr = '0;
            return;
        end
        if (drop) req_wr = '0;
        repeat (lat) @(negedge clk);
        mem_wr_ack = 1'b1;
        @(negedge clk);
        mem_wr_ack = 1'b0;
        req_wr = '0;
    endtask

    function automatic logic [N-1:0][DW-1:0] rand_data();
        logic [N-1:0][DW-1:0] d;
        for (int k = 0; k < N; k++) d[2'(k)] = DW'($urandom);
        return d;
    endfunction

    function automatic logic [N-1:0][2:0] rand_size();
        logic [N-1:0][2:0] s;
        for (int k = 0; k < N; k++) s[2'(k)] = 3'($urandom_range(0, 7));
        return s;
    endfunction

    always @(posedge clk) ack_seen <= mem_wr_ack && !rst;

    // Monitor: compares DUT activity against the scoreboard queues.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                rd_q.delete();
                wr_q.delete();
                rd_active = 1'b0;
                wr_active = 1'b0;
            end else begin
                check("grant_rd_onehot", 64'($countones(grant_rd) <= 1), 64'(1));
                check("grant_wr_onehot", 64'($countones(grant_wr) <= 1), 64'(1));
                if (valid != '0) begin
                    if (!rd_active) fail_now("spurious_valid", 64'(valid));
                    else begin
                        check("rd_valid", 64'(valid), 64'(rd_cur.grant));
                        check("rd_data", 64'(rd_data), 64'(rd_cur.d));
                        check("rd_grant_drop", 64'(grant_rd), 64'(0));
                        rd_active = 1'b0;
                        rd_done++;
                        $display("rd txn: grant=%b addr=0x%h data=0x%h", rd_cur.grant, rd_cur.a, rd_data);
                    end
                end else if (rd_active) begin
                    check("rd_grant_hold", 64'(grant_rd), 64'(rd_cur.grant));
                    check("rd_addr_hold", 64'(mem_rd_addr), 64'(rd_cur.a));
                    check("rd_en_pulse", 64'(mem_rd_en), 64'(0));
                end
                if (mem_rd_en && !rd_active) begin
                    if (rd_q.size() == 0) fail_now("unexpected_rd_en", 64'(mem_rd_addr));
                    else begin
                        rd_cur = rd_q.pop_front();
                        check("rd_grant", 64'(grant_rd), 64'(rd_cur.grant));
                        check("rd_addr", 64'(mem_rd_addr), 64'(rd_cur.a));
                        rd_active = 1'b1;
                    end
                end
                if (wr_active) begin
                    if (ack_seen) begin
                        check("wr_grant_drop", 64'(grant_wr), 64'(0));
                        wr_active = 1'b0;
                        wr_done++;
                        $display("wr txn: grant=%b addr=0x%h data=0x%h size=%0d",
                                 wr_cur.grant, wr_cur.a, wr_cur.d, wr_cur.sz);
                    end else begin
                        check("wr_grant_hold", 64'(grant_wr), 64'(wr_cur.grant));
                        check("wr_en_pulse", 64'(mem_wr_en), 64'(0));
                    end
                end else if (mem_wr_en) begin
                    if (wr_q.size() == 0) fail_now("unexpected_wr_en", 64'(mem_wr_addr));
                    else begin
                        wr_cur = wr_q.pop_front();
                        check("wr_grant", 64'(grant_wr), 64'(wr_cur.grant));
                        check("wr_addr", 64'(mem_wr_addr), 64'(wr_cur.a));
                        check("wr_data", 64'(mem_wr_data), 64'(wr_cur.d));
                        check("wr_size", 64'(mem_wr_size), 64'(wr_cur.sz));
                        wr_active = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        req_rd = '0; req_wr = '0;
        addr = '0; wr_data = '0; wr_size = '0;
        mem_rd_valid = 1'b0; mem_rd_data = '0; mem_wr_ack = 1'b0;
        n_checks = 0; n_errors = 0;
        rd_pushed = 0; rd_done = 0; wr_pushed = 0; wr_done = 0;
        rd_ptr_m = 0; wr_ptr_m = 0;
        for (int a = 0; a < 256; a++) mem[8'(a)] = DW'($urandom);
        mem[8'h40] = 16'hDEAD;

        repeat (3) @(negedge clk);
        check("reset_ctrl", 64'({grant_rd, grant_wr, valid, mem_rd_en, mem_wr_en}), 64'(0));
        check("reset_data", 64'({rd_data, mem_rd_addr, mem_wr_addr}), 64'(0));
        check("reset_wdata", 64'({mem_wr_data, mem_wr_size}), 64'(0));
        #2 rst = 1'b0;
        @(negedge clk);

        // Directed: full-load read rotation, single reader at 0x40, drop-while-waiting, proc 3 write.
        addr = {16'h0010, 16'h0040, 16'h0123, 16'h0456};
        fork
            begin
                for (int i = 0; i < 5; i++) rd_txn(4'b1111, 2, 1'b0);
                stray_rd();
                rd_txn(4'b0100, 1, 1'b0);
                rd_txn(4'b0010, 3, 1'b1);
            end
            begin
                wr_txn(4'b1000, {16'hBEEF, 16'h1111, 16'h2222, 16'h3333},
                       {3'd2, 3'd1, 3'd0, 3'd7}, 3, 1'b0);
                wr_txn(4'b0011, rand_data(), rand_size(), 0, 1'b1);
            end
        join

        // Same processor holding both grants at once, completing independently.
        fork
            rd_txn(4'b0010, 1, 1'b0);
            wr_txn(4'b0010, rand_data(), rand_size(), 4, 1'b0);
            begin
                @(negedge clk);
                check("conc_grant_rd", 64'(grant_rd), 64'(4'b0010));
                check("conc_grant_wr", 64'(grant_wr), 64'(4'b0010));
            end
        join

        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < N; k++) addr[2'(k)] = AW'($urandom);
            for (int a = 0; a < 256; a++) mem[8'(a)] = DW'($urandom);
            fork
                for (int t = 0; t < 8; t++) begin
                    if ($urandom_range(0, 4) == 0) stray_rd();
                    rd_txn(4'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(0, 3) == 0);
                end
                for (int t = 0; t < 8; t++)
                    wr_txn(4'($urandom_range(1, 15)), rand_data(), rand_size(),
                           $urandom_range(0, 3), $urandom_range(0, 3) == 0);
            join
        end

        // Abort both channels mid-transaction with reset, then send late responses.
        rd_txn(4'b0010, 0, 1'b0);
        wr_txn(4'b0010, rand_data(), rand_size(), 0, 1'b0);
        req_rd = 4'b1000;
        push_rd(4'b1000);
        wr_data = rand_data();
        wr_size = rand_size();
        req_wr = 4'b1000;
        push_wr(4'b1000);
        @(negedge clk);
        req_rd = '0;
        req_wr = '0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_async_grants", 64'({grant_rd, grant_wr}), 64'(0));
        check("rst_async_ctrl", 64'({valid, mem_rd_en, mem_wr_en, mem_wr_size}), 64'(0));
        check("rst_async_data", 64'({rd_data, mem_rd_addr, mem_wr_addr}), 64'(0));
        rd_pushed--;
        wr_pushed--;
        rd_ptr_m = 0;
        wr_ptr_m = 0;
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        mem_rd_valid = 1'b1;
        mem_wr_ack = 1'b1;
        @(negedge clk);
        mem_rd_valid = 1'b0;
        mem_wr_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_idle", 64'({grant_rd, grant_wr, valid}), 64'(0));
        rd_txn(4'b1111, 1, 1'b0);
        wr_txn(4'b1111, rand_data(), rand_size(), 1, 1'b0);

        repeat (4) @(negedge clk);
        check("rd_txn_count", 64'(rd_done), 64'(rd_pushed));
        check("wr_txn_count", 64'(wr_done), 64'(wr_pushed));
        check("queues_empty", 64'(rd_q.size() + wr_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pool_arbiter.md
POOL_ARBITER -- requirements
Module: pool_arbiter

Interface
REQ-001 The block SHALL have parameter N, default `PROC_COUNT, number of processors arbitrated.
REQ-002 The block SHALL have parameter DW, default `BUS_W, data width.
REQ-003 The block SHALL have parameter AW, default $bits(addr_t), address width.
REQ-004 Clocking and reset SHALL be one clock; reset is asynchronous and active-high.
REQ-005 i_clk  in  1  sole clock; all state updates on posedge.
REQ-006 i_rst  in  1  asynchronous active-high reset.
REQ-007 i_req_rd  in  N  per-processor read request.
REQ-008 i_req_wr  in  N  per-processor write request.
REQ-009 i_addr  in  N x AW  per-processor address.
REQ-010 i_data  in  N x DW  per-processor write data.
REQ-011 i_wr_size  in  N x 3  per-processor write size.
REQ-012 o_grant_rd  out  N  one-hot read grant, held for the transaction.
REQ-013 o_grant_wr  out  N  one-hot write grant, held for the transaction.
REQ-014 o_valid  out  N  one-cycle read-data-valid to the granted reader.
REQ-015 o_rd_data  out  DW  registered read data, broadcast to all processors.
REQ-016 o_mem_rd_en  out  1  one-cycle memory read strobe.
REQ-017 o_mem_rd_addr  out  AW  read address.
REQ-018 i_mem_rd_valid  in  1  memory read data valid.
REQ-019 i_mem_rd_data  in  DW  memory read data.
REQ-020 o_mem_wr_en  out  1  one-cycle memory write strobe.
REQ-021 o_mem_wr_addr  out  AW  write address.
REQ-022 o_mem_wr_data  out  DW  write data.
REQ-023 o_mem_wr_size  out  3  write size.
REQ-024 i_mem_wr_ack  in  1  memory write complete.

Function
REQ-025 The read and write channels SHALL be independent FSMs, each arbitrating round-robin among its own requesters.
REQ-026 The read FSM SHALL have states R_IDLE and R_WAIT.
REQ-027 In R_IDLE with any i_req_rd bit set at edge t, the read FSM SHALL select the first set bit at or above rd_ptr (wrapping N-1 -> 0), assert o_grant_rd[w] and o_mem_rd_en at cycle t+1, latch o_mem_rd_addr = i_addr[w], and enter R_WAIT.
REQ-028 o_mem_rd_en SHALL be high for exactly one cycle per transaction; o_mem_rd_addr SHALL hold until the transaction ends.
REQ-029 In R_WAIT on i_mem_rd_valid, the read FSM SHALL register o_rd_data = i_mem_rd_data, pulse o_valid[w] for one cycle in the next cycle, deassert o_grant_rd in that same cycle, set rd_ptr = (w+1) mod N, and return to R_IDLE.
REQ-030 i_mem_rd_valid in R_IDLE SHALL be ignored, with no o_valid pulse.
REQ-031 The write FSM SHALL have states W_IDLE and W_ACK, with the same selection rule as the read FSM using wr_ptr and i_req_wr.
REQ-032 On a write grant, the write FSM SHALL pulse o_mem_wr_en once and latch addr, data and size from the winner.
REQ-033 In W_ACK on i_mem_wr_ack, the write FSM SHALL drop o_grant_wr in the next cycle, set wr_ptr = (w+1) mod N, and return to W_IDLE.
REQ-034 Deassertion of a request while granted SHALL be ignored; the transaction completes.
REQ-035 A re-request SHALL not be granted in the cycle its grant drops; minimum one idle cycle between transactions on a channel.
REQ-036 The same processor SHALL be permitted to hold a read grant and a write grant simultaneously.
REQ-037 With a single persistent requester, it SHALL be re-granted every transaction; no starvation for any requester under full load (worst-case wait N-1 transactions).
REQ-038 o_grant_rd and o_grant_wr SHALL each be one-hot or zero at all times.

Reset
REQ-039 While i_rst is high, all outputs SHALL be 0, both FSMs SHALL be in the IDLE state, and rd_ptr = wr_ptr = 0.
REQ-040 Assertion of i_rst mid-transaction SHALL abort it immediately, with grants dropped asynchronously and no o_valid pulse; a late i_mem_rd_valid or i_mem_wr_ack after reset release SHALL be ignored.

Verification
REQ-041 Verification SHALL cover: N=4, i_req_rd=4'b1111 held, memory valid 2 cycles after rd_en -> grants in order 0,1,2,3,0, each with one o_valid pulse carrying the matching data.
REQ-042 Verification SHALL cover: i_req_rd[2] only, i_addr[2]=0x40, memory returns 0xDEAD -> o_mem_rd_addr=0x40, o_valid=4'b0100, o_rd_data=0xDEAD.
REQ-043 Verification SHALL cover: proc 1 requests read and write in the same cycle -> o_grant_rd=o_grant_wr=4'b0010 concurrently, with independent completion.
REQ-044 Verification SHALL cover: write from proc 3 (addr 0x10, data 0xBEEF, size 3'd2), ack after 3 cycles -> one o_mem_wr_en pulse with those values, grant held until the cycle after ack.
REQ-045 Verification SHALL cover: i_rst asserted in R_WAIT, then i_mem_rd_valid after release -> grants zero, no o_valid, FSM in R_IDLE, rd_ptr=0.
REQ-046 Verification SHALL cover: requester drops i_req_rd while in R_WAIT -> transaction still completes with an o_valid pulse.
